imem_boot_loader: RTL

- Boot/load controller for the byte-addressed instruction memory.
- Takes a framed byte stream (length header, payload, XOR checksum) and writes the payload into imem through a registered byte-write port.
- Holds the core in reset while loading.
- Owns the imem address mux between core fetch (cpu_pc) and loader writes.

---
 rtl/imem_boot_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream (16-bit length, payload, XOR checksum),
// writes the payload into imem and holds the core in reset while loading.
module imem_boot_loader #(
    parameter int unsigned ADDR_BUS_WIDTH = 16,
    parameter int unsigned MEM_BYTES      = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_req,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      rx_ready,
    input  logic [ADDR_BUS_WIDTH-1:0] cpu_pc,
    output logic [ADDR_BUS_WIDTH-1:0] imem_a,
    output logic                      imem_we,
    output logic [ADDR_BUS_WIDTH-1:0] imem_wa,
    output logic [7:0]                imem_wd,
    output logic                      cpu_rst_n,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned LEN_W = 16;

    typedef enum logic [2:0] {
        S_RUN    = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic [7:0]       csum;

    logic             xfer;
    logic [LEN_W-1:0] cnt_inc;
    logic [LEN_W-1:0] len_full;
    logic             len_bad;

    assign xfer     = rx_valid && rx_ready;
    assign cnt_inc  = cnt + LEN_W'(1);
    assign len_full = {len[15:8], rx_data};
    // Length must be non-zero, fit in imem and be a whole number of 32-bit words
    assign len_bad  = (len_full == '0) || (len_full > LEN_W'(MEM_BYTES)) || (len_full[1:0] != 2'b00);

    // The loader owns the imem read address whenever the core is held in reset
    assign imem_a = (state == S_RUN) ? cpu_pc : imem_wa;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            cpu_rst_n <= 1'b1;
            rx_ready  <= 1'b0;
            imem_we   <= 1'b0;
            imem_wa   <= '0;
            imem_wd   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            len       <= '0;
            cnt       <= '0;
            csum      <= '0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_RUN, S_ERROR: begin
                    if (load_req) begin
                        state     <= S_LEN_HI;
                        cnt       <= '0;
                        csum      <= '0;
                        err       <= 1'b0;
                        cpu_rst_n <= 1'b0;
                        rx_ready  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= rx_data;
                        state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= rx_data;
                        if (len_bad) begin
                            state    <= S_ERROR;
                            err      <= 1'b1;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        imem_we <= 1'b1;
                        imem_wa <= ADDR_BUS_WIDTH'(cnt);
                        imem_wd <= rx_data;
                        cnt     <= cnt_inc;
                        csum    <= csum ^ rx_data;
                        if (cnt_inc == len) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (rx_data == csum) begin
                            state     <= S_RUN;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule
